// File: rtl/multi_delay_timer_if.sv
// Control/status bundle for multi_delay_timer: per-channel start/stop/mode/value in,
// busy/done/remaining-count out.
interface multi_delay_timer_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
);
  logic [NCH-1:0]       start_port;
  logic [NCH-1:0]       stop_port;
  logic [NCH-1:0]       mode;
  logic [NCH*WIDTH-1:0] value;
  logic                 count_en;
  logic [NCH-1:0]       busy_port;
  logic [NCH-1:0]       done_port;
  logic [NCH*WIDTH-1:0] remaining_port;

  modport master (
    output start_port, stop_port, mode, value, count_en,
    input  busy_port, done_port, remaining_port
  );

  modport slave (
    input  start_port, stop_port, mode, value, count_en,
    output busy_port, done_port, remaining_port
  );
endinterface

// File: rtl/multi_delay_timer.sv
// NCH independent countdown channels with one-shot/periodic mode, cancel, shared count
// enable and a registered one-cycle done pulse per expiry.
module multi_delay_timer #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
) (
  input logic                clock,
  input logic                reset,
  multi_delay_timer_if.slave bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q     [NCH];
  logic [WIDTH-1:0] remaining_q [NCH];
  logic [WIDTH-1:0] period_q    [NCH];
  logic [NCH-1:0]   mode_q;
  logic [NCH-1:0]   done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i]     <= StIdle;
        remaining_q[i] <= '0;
        period_q[i]    <= '0;
      end
      mode_q <= '0;
      done_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        done_q[i] <= 1'b0;
        if (bus.start_port[i]) begin
          // Start wins over stop and restarts a running channel without a done.
          period_q[i]    <= bus.value[i*WIDTH +: WIDTH];
          mode_q[i]      <= bus.mode[i];
          remaining_q[i] <= bus.value[i*WIDTH +: WIDTH];
          if (bus.value[i*WIDTH +: WIDTH] == '0) begin
            done_q[i]  <= 1'b1;
            state_q[i] <= bus.mode[i] ? StRun : StIdle;
          end else begin
            state_q[i] <= StRun;
          end
        end else if (state_q[i] == StRun) begin
          if (bus.stop_port[i]) begin
            state_q[i]     <= StIdle;
            remaining_q[i] <= '0;
          end else if (bus.count_en) begin
            // remaining==0 only occurs for periodic N=0, which expires every tick.
            if (remaining_q[i] <= WIDTH'(1)) begin
              done_q[i] <= 1'b1;
              if (mode_q[i]) begin
                remaining_q[i] <= period_q[i];
              end else begin
                state_q[i]     <= StIdle;
                remaining_q[i] <= '0;
              end
            end else begin
              remaining_q[i] <= remaining_q[i] - WIDTH'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    bus.busy_port      = '0;
    bus.remaining_port = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.busy_port[i]                    = (state_q[i] == StRun);
      bus.remaining_port[i*WIDTH +: WIDTH] = remaining_q[i];
    end
  end

  assign bus.done_port = done_q;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Bench for multi_delay_timer (NCH=4, WIDTH=8): vector table, directed timing sequences
// and random stimulus, all compared each cycle against an elapsed-tick reference model.
module tb_multi_delay_timer;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multi_delay_timer_if #(.NCH(NCH), .WIDTH(W)) bus ();

  multi_delay_timer #(.NCH(NCH), .WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: per channel, count enabled ticks since arming; expiry at multiples of period.
  bit         m_armed [NCH];
  bit         m_md    [NCH];
  int         m_k     [NCH];
  int         m_per   [NCH];
  logic [3:0] m_done;

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [39:0] model_vec();
    logic [3:0]  b;
    logic [31:0] r;
    b = '0;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      b[c] = m_armed[c];
      if (m_armed[c] && m_per[c] != 0) r[c*W +: W] = 8'(m_per[c] - (m_k[c] % m_per[c]));
    end
    return {b, m_done, r};
  endfunction

  task automatic model_edge();
    m_done = '0;
    for (int c = 0; c < NCH; c++) begin
      int v;
      v = int'(bus.value[c*W +: W]);
      if (reset) begin
        m_armed[c] = 0; m_md[c] = 0; m_k[c] = 0; m_per[c] = 0;
      end else if (bus.start_port[c]) begin
        m_per[c] = v;
        m_md[c]  = bus.mode[c];
        m_k[c]   = 0;
        if (v == 0) begin
          m_done[c]  = 1'b1;
          m_armed[c] = bus.mode[c];
        end else begin
          m_armed[c] = 1;
        end
      end else if (m_armed[c] && bus.stop_port[c]) begin
        m_armed[c] = 0;
      end else if (m_armed[c] && bus.count_en) begin
        m_k[c]++;
        if (m_per[c] == 0) begin
          m_done[c] = 1'b1;
        end else if (m_k[c] % m_per[c] == 0) begin
          m_done[c] = 1'b1;
          if (!m_md[c]) m_armed[c] = 0;
        end
      end
    end
  endtask

  function automatic logic [39:0] dut_vec();
    return {bus.busy_port, bus.done_port, bus.remaining_port};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic quiet();
    bus.start_port = '0;
    bus.stop_port  = '0;
    bus.mode       = '0;
    bus.value      = '0;
    bus.count_en   = 1'b1;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  mode;
    logic [31:0] value;
    logic        en;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [31:0] rem;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] val;
    vecs[0]  = '{4'b0011, 4'b0000, 4'b0000, 32'h00000003, 1'b1, 4'b0001, 4'b0010, 32'h00000003};
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0001, 4'b0000, 32'h00000002};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0001, 4'b0000, 32'h00000001};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0001, 32'h00000000};
    vecs[4]  = '{4'b0100, 4'b0000, 4'b0100, 32'h00020000, 1'b1, 4'b0100, 4'b0000, 32'h00020000};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0100, 4'b0000, 32'h00020000};
    vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0100, 4'b0000, 32'h00010000};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0100, 4'b0100, 32'h00020000};
    vecs[8]  = '{4'b1000, 4'b0100, 4'b0000, 32'h01000000, 1'b1, 4'b1000, 4'b0000, 32'h01000000};
    vecs[9]  = '{4'b1000, 4'b1000, 4'b0000, 32'h04000000, 1'b1, 4'b1000, 4'b0000, 32'h04000000};
    vecs[10] = '{4'b0000, 4'b1000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 32'h00000000};

    do_reset();
    check("reset_state", dut_vec(), 40'h0);

    foreach (vecs[i]) begin
      bus.start_port = vecs[i].start;
      bus.stop_port  = vecs[i].stop;
      bus.mode       = vecs[i].mode;
      bus.value      = vecs[i].value;
      bus.count_en   = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i), dut_vec(), {vecs[i].busy, vecs[i].done, vecs[i].rem});
    end

    // One-shot N=5 on ch0: remaining 5..1, done exactly five cycles after the first load.
    do_reset();
    bus.start_port = 4'b0001;
    bus.value      = 32'h5;
    tick();
    quiet();
    for (int j = 0; j < 5; j++) begin
      check("oneshot5_run", {bus.busy_port[0], bus.done_port[0], 24'h0, bus.remaining_port[7:0]},
            {1'b1, 1'b0, 24'h0, 8'(5 - j)});
      tick();
    end
    check("oneshot5_done", dut_vec(), {4'b0000, 4'b0001, 32'h0});

    // N=0 one-shot then N=0 periodic on ch1.
    bus.start_port = 4'b0010;
    tick();
    quiet();
    check("n0_oneshot", dut_vec(), {4'b0000, 4'b0010, 32'h0});
    tick();
    check("n0_oneshot_after", dut_vec(), 40'h0);
    bus.start_port = 4'b0010;
    bus.mode       = 4'b0010;
    tick();
    quiet();
    for (int j = 0; j < 3; j++) begin
      check("n0_periodic", dut_vec(), {4'b0010, 4'b0010, 32'h0});
      tick();
    end
    bus.stop_port = 4'b0010;
    tick();
    quiet();
    check("n0_periodic_stop", dut_vec(), 40'h0);

    // Periodic N=3 on ch2 from t=0, stop applied during t=8.
    bus.start_port = 4'b0100;
    bus.mode       = 4'b0100;
    bus.value      = 32'h00030000;
    tick();
    quiet();
    for (int t = 1; t <= 11; t++) begin
      check("periodic3", {38'h0, bus.busy_port[2], bus.done_port[2]},
            {38'h0, (t <= 8), (t == 4 || t == 7)});
      if (t == 8) bus.stop_port = 4'b0100;
      tick();
      quiet();
    end

    // Ch3 N=10 restarted with N=2 at t=4: single done at t=7.
    bus.start_port = 4'b1000;
    bus.value      = 32'h0A000000;
    tick();
    quiet();
    for (int t = 1; t <= 12; t++) begin
      check("restart", {39'h0, bus.done_port[3]}, {39'h0, (t == 7)});
      if (t == 4) begin
        bus.start_port = 4'b1000;
        bus.value      = 32'h02000000;
      end
      tick();
      quiet();
    end

    // All channels N=6 with count_en low for cycles 2..5: common done at t=11.
    bus.start_port = 4'b1111;
    bus.value      = 32'h06060606;
    tick();
    quiet();
    for (int t = 1; t <= 12; t++) begin
      check("stall_all", {36'h0, bus.done_port}, {36'h0, (t == 11) ? 4'b1111 : 4'b0000});
      bus.count_en = !(t >= 2 && t <= 5);
      tick();
    end
    quiet();

    // Reset mid-run, then no further done without a new start.
    bus.start_port = 4'b0011;
    bus.mode       = 4'b0001;
    bus.value      = 32'h00000502;
    tick();
    quiet();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("reset_midrun", dut_vec(), 40'h0);
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      check("post_reset_quiet", dut_vec(), 40'h0);
    end

    // Full-scale N=255: done at t+256.
    bus.start_port = 4'b0001;
    bus.value      = 32'h000000FF;
    tick();
    quiet();
    for (int t = 1; t <= 257; t++) begin
      if (t == 1 || t >= 255)
        check("n255", {39'h0, bus.done_port[0]}, {39'h0, (t == 256)});
      tick();
    end

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        val[c*W +: W] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
        bus.start_port[c] = ($urandom_range(0, 7) == 0);
        bus.stop_port[c]  = ($urandom_range(0, 15) == 0);
        bus.mode[c]       = 1'($urandom);
      end
      bus.value    = val;
      bus.count_en = ($urandom_range(0, 4) != 0);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
